// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block and the generator side of the link:
// FSM state encodings and the default counter width.
package pwm_capture_pkg;

  localparam int PWM_CW = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchroniser plus a delay flop for an asynchronous level input.
// Produces the synchronised level and single-cycle rise/fall strobes.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= d_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign lvl  = s2_reg;
  assign rise = s2_reg & ~s3_reg;
  assign fall = ~s2_reg & s3_reg;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an incoming PWM signal in clk cycles,
// reporting once per complete period and flagging a stuck (0 % / 100 %) input.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CW = PWM_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pwm_in,
  output logic [CW-1:0] width_out,
  output logic [CW-1:0] period_out,
  output logic          duty_valid,
  output logic          stuck,
  output logic          stuck_lvl
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          lvl;
  logic          rise;
  logic          fall;
  pwm_state_t    state_reg;
  logic [CW-1:0] hcnt_reg;
  logic [CW-1:0] pcnt_reg;
  logic [CW-1:0] hcnt_inc;
  logic [CW-1:0] pcnt_inc;
  logic          pcnt_sat;

  pwm_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (pwm_in),
    .lvl  (lvl),
    .rise (rise),
    .fall (fall)
  );

  // Saturating increments; pcnt_sat marks the update that would reach the ceiling.
  assign hcnt_inc = (hcnt_reg == CNT_MAX) ? CNT_MAX : hcnt_reg + CNT_ONE;
  assign pcnt_inc = (pcnt_reg == CNT_MAX) ? CNT_MAX : pcnt_reg + CNT_ONE;
  assign pcnt_sat = (pcnt_inc == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      hcnt_reg   <= '0;
      pcnt_reg   <= '0;
      width_out  <= '0;
      period_out <= '0;
      duty_valid <= 1'b0;
      stuck      <= 1'b0;
      stuck_lvl  <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (!en) begin
        state_reg <= ST_IDLE;
        hcnt_reg  <= '0;
        pcnt_reg  <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            // The first rise only opens a period; nothing is reported from it.
            if (rise) begin
              state_reg <= ST_HIGH;
              hcnt_reg  <= CNT_ONE;
              pcnt_reg  <= CNT_ONE;
            end else if (pcnt_reg != CNT_MAX) begin
              pcnt_reg <= pcnt_inc;
              if (pcnt_sat) begin
                stuck     <= 1'b1;
                stuck_lvl <= lvl;
              end
            end
          end
          ST_HIGH: begin
            if (pcnt_sat) begin
              state_reg <= ST_IDLE;
              hcnt_reg  <= '0;
              pcnt_reg  <= '0;
              stuck     <= 1'b1;
              stuck_lvl <= 1'b1;
            end else begin
              pcnt_reg <= pcnt_inc;
              if (fall) begin
                state_reg <= ST_LOW;
              end else begin
                hcnt_reg <= hcnt_inc;
              end
            end
          end
          ST_LOW: begin
            // Rise closes the period and opens the next; it beats saturation.
            if (rise) begin
              width_out  <= hcnt_reg;
              period_out <= pcnt_reg;
              duty_valid <= 1'b1;
              stuck      <= 1'b0;
              state_reg  <= ST_HIGH;
              hcnt_reg   <= CNT_ONE;
              pcnt_reg   <= CNT_ONE;
            end else if (pcnt_sat) begin
              state_reg <= ST_IDLE;
              hcnt_reg  <= '0;
              pcnt_reg  <= '0;
              stuck     <= 1'b1;
              stuck_lvl <= 1'b0;
            end else begin
              pcnt_reg <= pcnt_inc;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            hcnt_reg  <= '0;
            pcnt_reg  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised bench for pwm_capture: a timestamp-based reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_pwm_capture;

  localparam int  CW   = 9;
  localparam longint MAXC = 511;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          pwm_in;
  logic [CW-1:0] width_out;
  logic [CW-1:0] period_out;
  logic          duty_valid;
  logic          stuck;
  logic          stuck_lvl;

  pwm_capture #(.CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pwm_in     (pwm_in),
    .width_out  (width_out),
    .period_out (period_out),
    .duty_valid (duty_valid),
    .stuck      (stuck),
    .stuck_lvl  (stuck_lvl)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dv_seen = 0;
  int pat_ph = 0;

  // Reference model: pwm_in history gives the synchronised level; the measurement is
  // kept as cycle timestamps of the opening rise, the fall, and the start of idling.
  bit     hist [0:2];
  longint cyc = 0;
  bit     measuring;
  longint rise_t, fall_t, idle_t;
  int     m_width, m_period;
  bit     m_dv, m_stuck, m_lvl;

  task automatic model_step();
    bit lv, pv, r, f;
    longint el;
    lv = hist[1];
    pv = hist[2];
    r  = lv & ~pv;
    f  = ~lv & pv;
    m_dv = 1'b0;
    if (rst) begin
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
      measuring = 0;
      idle_t = cyc + 1;
      m_width = 0; m_period = 0; m_stuck = 0; m_lvl = 0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = pwm_in;
      if (!en) begin
        measuring = 0;
        idle_t = cyc + 1;
      end else if (!measuring) begin
        if (r) begin
          measuring = 1; rise_t = cyc; fall_t = -1;
        end else if (cyc - idle_t + 1 == MAXC) begin
          m_stuck = 1; m_lvl = lv;
        end
      end else begin
        el = cyc - rise_t + 1;
        if (fall_t < 0) begin
          if (el == MAXC) begin
            measuring = 0; idle_t = cyc + 1; m_stuck = 1; m_lvl = 1;
          end else if (f) begin
            fall_t = cyc;
          end
        end else if (r) begin
          m_width  = int'(fall_t - rise_t);
          m_period = int'(cyc - rise_t);
          m_dv = 1; m_stuck = 0;
          rise_t = cyc; fall_t = -1;
        end else if (el == MAXC) begin
          measuring = 0; idle_t = cyc + 1; m_stuck = 1; m_lvl = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_cycle();
    if (!rst) begin
      if (duty_valid) dv_seen++;
      checks++;
      if (int'(width_out) != m_width || int'(period_out) != m_period ||
          duty_valid != m_dv || stuck != m_stuck || stuck_lvl != m_lvl) begin
        errors++;
        $display("FAIL cycle_compare @%0d: dut w=%0d p=%0d dv=%0b st=%0b lv=%0b, model w=%0d p=%0d dv=%0b st=%0b lv=%0b",
                 cyc, width_out, period_out, duty_valid, stuck, stuck_lvl,
                 m_width, m_period, m_dv, m_stuck, m_lvl);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_pat(input int h, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = ((pat_ph % p) < h);
      pat_ph++;
      tick();
    end
  endtask

  task automatic hold(input bit level, input int n);
    pwm_in = level;
    repeat (n) tick();
  endtask

  task automatic lit_zero_outputs(input string tag);
    lit({tag, "_width"},  int'(width_out),  0);
    lit({tag, "_period"}, int'(period_out), 0);
    lit({tag, "_dv"},     int'(duty_valid), 0);
    lit({tag, "_stuck"},  int'(stuck),      0);
    lit({tag, "_lvl"},    int'(stuck_lvl),  0);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    lit_zero_outputs(tag);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv0, h, l, r;
    rst = 1'b1; en = 1'b0; pwm_in = 1'b0;
    repeat (3) tick();
    lit_zero_outputs("reset");
    rst = 1'b0;
    en = 1'b1;

    // Input held low from reset: stuck low after 511 cycles, results stay zero.
    hold(1'b0, 505);
    lit("stuck_early", int'(stuck), 0);
    hold(1'b0, 10);
    lit("stuck_low", int'(stuck), 1);
    lit("stuck_low_lvl", int'(stuck_lvl), 0);
    lit("stuck_low_width", int'(width_out), 0);
    lit("stuck_low_period", int'(period_out), 0);

    // High 3 / low 5: a rise in IDLE leaves stuck set; first report is 3/8.
    pat_ph = 0;
    run_pat(3, 8, 4);
    lit("idle_rise_keeps_stuck", int'(stuck), 1);
    run_pat(3, 8, 36);
    lit("p38_width", int'(width_out), 3);
    lit("p38_period", int'(period_out), 8);
    lit("p38_stuck_cleared", int'(stuck), 0);

    // duty_valid appears on the third edge after pwm_in goes high.
    pwm_in = 1'b1;
    tick(); lit("dv_lat_edge1", int'(duty_valid), 0);
    tick(); lit("dv_lat_edge2", int'(duty_valid), 0);
    tick(); lit("dv_lat_edge3", int'(duty_valid), 1);
    pat_ph = 3;
    run_pat(3, 8, 21);

    // Held high: stuck high, then recovery on the next report.
    hold(1'b1, 520);
    lit("stuck_high", int'(stuck), 1);
    lit("stuck_high_lvl", int'(stuck_lvl), 1);
    pat_ph = 0;
    run_pat(3, 8, 40);
    lit("recover_stuck", int'(stuck), 0);
    lit("recover_width", int'(width_out), 3);
    lit("recover_period", int'(period_out), 8);

    // en dropped mid-HIGH for 10 cycles: outputs hold, next report is a full period.
    run_pat(3, 8, 3);
    en = 1'b0;
    dv0 = dv_seen;
    run_pat(3, 8, 10);
    lit("en_low_no_dv", dv_seen - dv0, 0);
    lit("en_low_width_hold", int'(width_out), 3);
    lit("en_low_period_hold", int'(period_out), 8);
    en = 1'b1;
    run_pat(3, 8, 27);
    lit("en_back_dv", int'(dv_seen > dv0), 1);
    lit("en_back_width", int'(width_out), 3);
    lit("en_back_period", int'(period_out), 8);

    // Generator-like 64/256 waveform.
    pat_ph = 0;
    run_pat(64, 256, 256 * 3 + 5);
    lit("gen_width", int'(width_out), 64);
    lit("gen_period", int'(period_out), 256);

    // Reset mid-HIGH: outputs clear at once; the partial period is not reported.
    hold(1'b1, 2);
    reset_pulse("midrun_reset");
    dv0 = dv_seen;
    hold(1'b1, 2);
    hold(1'b0, 5);
    lit("post_reset_no_dv", dv_seen - dv0, 0);
    hold(1'b1, 3);
    hold(1'b0, 5);
    lit("post_reset_width", int'(width_out), 2);
    lit("post_reset_period", int'(period_out), 7);

    // Randomised segments: glitches, en drops, long holds and resets.
    for (int it = 0; it < 160; it++) begin
      h = int'($urandom_range(1, 30));
      l = int'($urandom_range(1, 30));
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        en = 1'b0;
        hold(1'b1, h);
        hold(1'b0, l);
        en = 1'b1;
      end else if (r == 1) begin
        reset_pulse("rand_reset");
      end else if (r == 2) begin
        hold(1'($urandom_range(0, 1)), int'($urandom_range(500, 540)));
      end else begin
        hold(1'b1, h);
        hold(1'b0, l);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
